// File: rtl/ppu_pkg.sv
// Shared PPU definitions: register indices, the sprite-DMA trigger address
// and the oam_dma FSM state type.
package ppu_pkg;

  localparam logic [2:0] PPUCTRL   = 3'd0;
  localparam logic [2:0] PPUMASK   = 3'd1;
  localparam logic [2:0] PPUSTATUS = 3'd2;
  localparam logic [2:0] OAMADDR   = 3'd3;
  localparam logic [2:0] OAMDATA   = 3'd4;
  localparam logic [2:0] PPUSCROLL = 3'd5;
  localparam logic [2:0] PPUADDR   = 3'd6;
  localparam logic [2:0] PPUDATA   = 3'd7;

  localparam logic [15:0] DMA_REG_ADDR = 16'h4014;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HALT    = 3'd1,
    S_READ    = 3'd2,
    S_CAPTURE = 3'd3,
    S_WRITE   = 3'd4,
    S_RELEASE = 3'd5,
    S_DONE    = 3'd6
  } oam_dma_state_t;

endpackage

// File: rtl/oam_dma_if.sv
// CPU, memory and PPU-register signals seen by the sprite DMA engine.
// master = the DMA engine, slave = the surrounding system.
interface oam_dma_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_WE;
  logic        cpu_halt;
  logic        dma_active;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        ppu_cs_n;
  logic        ppu_WE;
  logic [2:0]  ppu_reg_addr;
  logic [7:0]  ppu_wdata;
  logic        done;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_WE, mem_rdata,
    output cpu_halt, dma_active, mem_addr, mem_rd,
    output ppu_cs_n, ppu_WE, ppu_reg_addr, ppu_wdata, done
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_WE, mem_rdata,
    input  cpu_halt, dma_active, mem_addr, mem_rd,
    input  ppu_cs_n, ppu_WE, ppu_reg_addr, ppu_wdata, done
  );

endinterface

// File: rtl/oam_dma.sv
// $4014 sprite DMA: copies CPU page $PP00-$PPFF into PPU OAMDATA, one byte
// every 4 cycles, while holding the CPU stalled.
module oam_dma
  import ppu_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = ppu_pkg::DMA_REG_ADDR,
  parameter logic [2:0]  OAMDATA_REG  = OAMDATA,
  parameter int unsigned HALT_CYCLES  = 1
) (
  input  logic      clk,
  input  logic      reset,
  oam_dma_if.master bus
);

  localparam logic [7:0] HALT_LAST = 8'(HALT_CYCLES - 1);

  oam_dma_state_t state_r, state_nx_s;
  logic [7:0]  page_r, page_nx_s;
  logic [7:0]  idx_r, idx_nx_s;
  logic [7:0]  halt_cnt_r, halt_cnt_nx_s;
  logic        trig_q_r, trig_cond_s, trig_s, busy_nx_s;

  logic        cpu_halt_r, dma_active_r, mem_rd_r, ppu_cs_n_r, ppu_we_r, done_r;
  logic [15:0] mem_addr_r;
  logic [7:0]  ppu_wdata_r;

  assign bus.cpu_halt     = cpu_halt_r;
  assign bus.dma_active   = dma_active_r;
  assign bus.mem_addr     = mem_addr_r;
  assign bus.mem_rd       = mem_rd_r;
  assign bus.ppu_cs_n     = ppu_cs_n_r;
  assign bus.ppu_WE       = ppu_we_r;
  assign bus.ppu_reg_addr = OAMDATA_REG;
  assign bus.ppu_wdata    = ppu_wdata_r;
  assign bus.done         = done_r;

  // Trigger edge detect and next-state / counter logic.
  always_comb begin
    trig_cond_s   = bus.cpu_WE && (bus.cpu_addr == DMA_REG_ADDR);
    trig_s        = trig_cond_s && !trig_q_r;
    state_nx_s    = state_r;
    page_nx_s     = page_r;
    idx_nx_s      = idx_r;
    halt_cnt_nx_s = halt_cnt_r;
    case (state_r)
      S_IDLE: begin
        if (trig_s) begin
          page_nx_s     = bus.cpu_wdata;
          halt_cnt_nx_s = 8'd0;
          state_nx_s    = S_HALT;
        end else begin
          state_nx_s    = S_IDLE;
        end
      end
      S_HALT: begin
        if (halt_cnt_r == HALT_LAST) begin
          state_nx_s    = S_READ;
        end else begin
          halt_cnt_nx_s = halt_cnt_r + 8'd1;
        end
      end
      S_READ:    state_nx_s = S_CAPTURE;
      S_CAPTURE: state_nx_s = S_WRITE;
      S_WRITE:   state_nx_s = S_RELEASE;
      S_RELEASE: begin
        // idx stops at $FF so the transfer never spills into page+1
        if (idx_r == 8'hFF) begin
          state_nx_s = S_DONE;
        end else begin
          idx_nx_s   = idx_r + 8'd1;
          state_nx_s = S_READ;
        end
      end
      S_DONE: begin
        idx_nx_s   = 8'd0;
        state_nx_s = S_IDLE;
      end
      default: state_nx_s = S_IDLE;
    endcase
    busy_nx_s = (state_nx_s == S_HALT) || (state_nx_s == S_READ) ||
                (state_nx_s == S_CAPTURE) || (state_nx_s == S_WRITE) ||
                (state_nx_s == S_RELEASE);
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // each one is valid for exactly the cycle its state is occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      page_r       <= 8'd0;
      idx_r        <= 8'd0;
      halt_cnt_r   <= 8'd0;
      trig_q_r     <= 1'b0;
      cpu_halt_r   <= 1'b0;
      dma_active_r <= 1'b0;
      mem_addr_r   <= 16'd0;
      mem_rd_r     <= 1'b0;
      ppu_cs_n_r   <= 1'b1;
      ppu_we_r     <= 1'b0;
      ppu_wdata_r  <= 8'd0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      page_r       <= page_nx_s;
      idx_r        <= idx_nx_s;
      halt_cnt_r   <= halt_cnt_nx_s;
      trig_q_r     <= trig_cond_s;
      cpu_halt_r   <= busy_nx_s;
      dma_active_r <= busy_nx_s;
      mem_rd_r     <= (state_nx_s == S_READ);
      ppu_cs_n_r   <= (state_nx_s != S_WRITE);
      ppu_we_r     <= (state_nx_s == S_WRITE);
      done_r       <= (state_nx_s == S_DONE);
      if (state_nx_s == S_READ) begin
        mem_addr_r <= {page_nx_s, idx_nx_s};
      end else begin
        mem_addr_r <= mem_addr_r;
      end
      // mem_rdata is valid in the capture cycle; it is held for the write
      if (state_r == S_CAPTURE) begin
        ppu_wdata_r <= bus.mem_rdata;
      end else begin
        ppu_wdata_r <= ppu_wdata_r;
      end
    end
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- CPU-side initiator for the PPU register interface. It implements the $4014 sprite DMA.
- A CPU write of page PP to $4014 stalls the CPU. The block then reads CPU memory $PP00–$PPFF and writes each byte to PPU register 4 (OAMDATA) using the PPU's active-low, edge-detected chip-select protocol.
- It sits between the CPU bus/RAM arbiter and the PPU register port. `dma_active` steers the top-level muxes.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a DMA.
- OAMDATA_REG, 3'd4, PPU register index written per byte.
- HALT_CYCLES, 1, idle cycles after the trigger before the first read (lets the CPU reach a stall).

Ports:
- clk  in  1  system clock; all logic is posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU bus address.
- cpu_wdata  in  8  CPU write data.
- cpu_WE  in  1  CPU write strobe.
- cpu_halt  out  1  CPU stall request; equals dma_active.
- dma_active  out  1  high while the DMA owns the memory and PPU register buses.
- mem_addr  out  16  memory read address.
- mem_rd  out  1  memory read request.
- mem_rdata  in  8  memory read data, valid exactly 1 cycle after mem_rd.
- ppu_cs_n  out  1  PPU register chip select, active low.
- ppu_WE  out  1  PPU register write enable.
- ppu_reg_addr  out  3  PPU register index; constant OAMDATA_REG.
- ppu_wdata  out  8  data to the PPU register.
- done  out  1  one-cycle pulse when a DMA completes.

Behaviour:
- All outputs are registered.
- Reset values:
  - cpu_halt = 0, dma_active = 0.
  - mem_addr = 0, mem_rd = 0.
  - ppu_cs_n = 1, ppu_WE = 0, ppu_wdata = 0.
  - done = 0.
  - FSM = S_IDLE, idx = 0, page = 0.
- Trigger:
  - trig = cpu_WE & (cpu_addr == DMA_REG_ADDR) & ~trig_q, where trig_q is trig's input condition registered.
  - A held write therefore fires once.
  - On trig in S_IDLE: latch page <= cpu_wdata, go to S_HALT.
  - From the next cycle, cpu_halt = 1 and dma_active = 1.
- FSM states:
  - S_IDLE → S_HALT on trig.
  - S_HALT: count HALT_CYCLES cycles, then go to S_READ.
  - S_READ: mem_addr = {page, idx}, mem_rd = 1 for this cycle only; → S_CAPTURE.
  - S_CAPTURE: byte_q <= mem_rdata; mem_rd = 0; → S_WRITE.
  - S_WRITE: ppu_cs_n = 0, ppu_WE = 1, ppu_wdata = byte_q for exactly one cycle; → S_RELEASE.
  - S_RELEASE: ppu_cs_n = 1, ppu_WE = 0.
    - If idx == 8'hFF: → S_DONE.
    - Otherwise: idx <= idx + 1 and → S_READ.
  - S_DONE: done = 1, cpu_halt = 0, dma_active = 0, idx <= 0; → S_IDLE.
- Chip-select spacing: ppu_cs_n is high for at least 3 cycles between the low pulses, so the PPU's falling-edge detector sees one access per byte.
- Timing:
  - 4 cycles per byte.
  - cpu_halt is high for exactly HALT_CYCLES + 1024 cycles.
  - done pulses on the cycle cpu_halt falls.
- Width rules:
  - idx is 8 bits; the wrap at $FF terminates the transfer and never crosses into page+1.
  - page $FF reads $FF00–$FFFF.
- Simultaneous events:
  - trig while not in S_IDLE is ignored; page is unchanged.
  - trig in the S_DONE cycle is ignored.
- Reset mid-DMA: on the next edge, all outputs return to their reset values and the FSM goes to S_IDLE. ppu_cs_n goes high even mid-write. No done pulse is issued.
- The block never drives OAMADDR. Bytes land starting at the PPU's current OAM address, which auto-increments.

Decomposition:
- Shared package ppu_pkg:
  - PPU register indices PPUCTRL..PPUDATA (3'd0–3'd7).
  - DMA_REG_ADDR.
  - oam_dma_state_t enum: S_IDLE, S_HALT, S_READ, S_CAPTURE, S_WRITE, S_RELEASE, S_DONE.
- The single FSM with counters is compact enough that no sub-module is needed. The trigger edge detect is inline.

Test Plan:
- Basic DMA:
  - Stimulus: preload RAM $0200+i = i^8'hA5; write 8'h02 to $4014.
  - Response: 256 ppu_cs_n low pulses, each with ppu_reg_addr = 4, ppu_WE = 1 and ppu_wdata = i^A5 in order.
  - Response: mem_addr runs $0200–$02FF; cpu_halt is high for 1025 cycles; done pulses once.
- Held trigger:
  - Stimulus: cpu_WE held with cpu_addr = $4014 for 5 cycles.
  - Response: exactly one DMA (256 writes).
- Re-trigger while busy:
  - Stimulus: at byte 10, a second write of $07 to $4014.
  - Response: ignored; all addresses stay in page $02; total 256 writes.
- Page $FF boundary:
  - Stimulus: DMA from page $FF.
  - Response: last mem_addr = $FFFF; no access to $0000; done pulses after byte 255.
- Reset mid-DMA:
  - Stimulus: assert reset during the S_WRITE of byte 100.
  - Response: next edge gives ppu_cs_n = 1, cpu_halt = 0, no done pulse.
  - Response: a subsequent DMA of page $03 completes normally with 256 writes.
- Chip-select spacing and protocol:
  - Check: every ppu_cs_n low pulse lasts exactly 1 cycle, followed by at least 3 high cycles.
  - Check: a behavioural PPU register model counts 256 OAMDATA writes and its OAM address advances by 256 (wraps to its start).
